// File: rtl/etapa_fetch_pkg.sv
// Constants shared by the fetch stage: HALT/bubble encodings and FSM state codes.
// HALT and the bubble are both the all-zero word; only the valid bit distinguishes them.
package etapa_fetch_pkg;

  localparam logic [31:0] HALT_OPCODE = 32'h0000_0000;
  localparam logic [31:0] NOP_BUBBLE  = 32'h0000_0000;

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_HALTED = 1'b1;

endpackage

// File: rtl/etapa_fetch_if.sv
// Control, program-load and instruction-output bundle between the fetch stage and its neighbours.
// master = debug unit / pipeline control driving the stage; slave = the fetch stage itself.
interface etapa_fetch_if #(
  parameter int CANT_BITS_INSTRUCTION = 32,
  parameter int CANT_BITS_ADDR        = 11
);

  logic                             i_enable;
  logic                             i_stall;
  logic                             i_flush;
  logic [CANT_BITS_ADDR-1:0]        i_branch_target;
  logic                             i_mem_wr_en;
  logic [CANT_BITS_ADDR-1:0]        i_mem_wr_addr;
  logic [CANT_BITS_INSTRUCTION-1:0] i_mem_wr_data;
  logic [CANT_BITS_INSTRUCTION-1:0] o_instruction;
  logic                             o_valid;
  logic [CANT_BITS_ADDR-1:0]        o_pc;
  logic [CANT_BITS_ADDR-1:0]        o_pc_plus_one;
  logic                             o_halt;

  modport master (
    output i_enable, i_stall, i_flush, i_branch_target,
           i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    input  o_instruction, o_valid, o_pc, o_pc_plus_one, o_halt
  );

  modport slave (
    input  i_enable, i_stall, i_flush, i_branch_target,
           i_mem_wr_en, i_mem_wr_addr, i_mem_wr_data,
    output o_instruction, o_valid, o_pc, o_pc_plus_one, o_halt
  );

endinterface

// File: rtl/etapa_fetch_memoria_instrucciones.sv
// Instruction memory: one write port for program load, one registered read port.
// Latency: 1 cycle read. Backpressure: read register holds whenever i_rd_en is low.
// Write is independent of read enable; same-address read+write returns the old word.
module memoria_instrucciones #(
  parameter int CANT_BITS_INSTRUCTION = 32,
  parameter int CANT_BITS_ADDR        = 11
) (
  input  logic                             i_clock,
  input  logic                             i_rd_en,
  input  logic [CANT_BITS_ADDR-1:0]        i_rd_addr,
  output logic [CANT_BITS_INSTRUCTION-1:0] o_rd_data,
  input  logic                             i_wr_en,
  input  logic [CANT_BITS_ADDR-1:0]        i_wr_addr,
  input  logic [CANT_BITS_INSTRUCTION-1:0] i_wr_data
);

  logic [CANT_BITS_INSTRUCTION-1:0] mem [0:(1<<CANT_BITS_ADDR)-1];

  always_ff @(posedge i_clock) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
    if (i_rd_en) begin
      o_rd_data <= mem[i_rd_addr];
    end
  end

endmodule

// File: rtl/etapa_fetch.sv
// MIPS instruction-fetch stage: PC, instruction memory, valid/pc+1 registers, HALT FSM.
// Latency: 1 cycle PC -> o_instruction. Backpressure: i_stall/!i_enable hold all state; flush wins over stall.
// HALT is sticky until reset; a HALT seen on a flushed path is discarded.
module etapa_fetch
  import etapa_fetch_pkg::*;
#(
  parameter int CANT_BITS_INSTRUCTION = 32,
  parameter int CANT_BITS_ADDR        = 11
) (
  input  logic         i_clock,
  input  logic         i_soft_reset,
  etapa_fetch_if.slave fetch_bus
);

  logic [CANT_BITS_ADDR-1:0]        pc;
  logic [CANT_BITS_ADDR-1:0]        pc_inc;
  logic [CANT_BITS_ADDR-1:0]        pc_plus_one;
  logic                             valid;
  logic [0:0]                       state;
  logic [CANT_BITS_INSTRUCTION-1:0] rd_data;
  logic                             running;
  logic                             halt_detect;
  logic                             do_flush;
  logic                             advance;

  assign pc_inc  = pc + 1'b1;
  assign running = fetch_bus.i_enable && (state == ST_RUN);

  // Only a real fetched zero word halts; a bubble is also zero but has valid=0.
  assign halt_detect = running && valid && !fetch_bus.i_flush &&
                       (rd_data == CANT_BITS_INSTRUCTION'(HALT_OPCODE));
  assign do_flush    = running && fetch_bus.i_flush;
  assign advance     = running && !fetch_bus.i_flush && !fetch_bus.i_stall && !halt_detect;

  memoria_instrucciones #(
    .CANT_BITS_INSTRUCTION (CANT_BITS_INSTRUCTION),
    .CANT_BITS_ADDR        (CANT_BITS_ADDR)
  ) u_memoria (
    .i_clock   (i_clock),
    .i_rd_en   (advance),
    .i_rd_addr (pc),
    .o_rd_data (rd_data),
    .i_wr_en   (fetch_bus.i_mem_wr_en),
    .i_wr_addr (fetch_bus.i_mem_wr_addr),
    .i_wr_data (fetch_bus.i_mem_wr_data)
  );

  always_ff @(posedge i_clock or negedge i_soft_reset) begin
    if (!i_soft_reset) begin
      state       <= ST_RUN;
      pc          <= '0;
      pc_plus_one <= '0;
      valid       <= 1'b0;
    end else if (do_flush) begin
      pc    <= fetch_bus.i_branch_target;
      valid <= 1'b0;
    end else if (halt_detect) begin
      state <= ST_HALTED;
    end else if (advance) begin
      pc          <= pc_inc;
      pc_plus_one <= pc_inc;
      valid       <= 1'b1;
    end
  end

  assign fetch_bus.o_instruction = valid ? rd_data : CANT_BITS_INSTRUCTION'(NOP_BUBBLE);
  assign fetch_bus.o_valid       = valid;
  assign fetch_bus.o_pc          = pc;
  assign fetch_bus.o_pc_plus_one = pc_plus_one;
  assign fetch_bus.o_halt        = (state == ST_HALTED);

endmodule
